// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the RV32 front end.
//   - opcode constants for the instruction classes the controller decodes
//   - NOP_INSTR: canonical NOP (addi x0, x0, 0), used as the reset value of Instr
//   - fetch_state_e: state encoding for the fetch FSM
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: XLEN-wide register with load enable, reset asynchronously to RESET_PC.
// Ports:
//   clk   in  clock (rising edge)
//   reset in  asynchronous active-high reset
//   load  in  capture d on the next rising edge
//   d     in  next value
//   q     out current value
module pc_reg #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the controller.
// Requests the instruction at PC, latches it into Instr, holds it issued until
// retired, then advances PC by 4 or to the branch/jump target.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   PCSrc, PCTarget      next-PC select and target, sampled when retiring
//   stall                holds the issued instruction in place
//   imem_req, imem_addr  fetch request and address (= PC)
//   imem_valid, imem_rdata  fetch response
//   Instr, op, funct3, funct7b5  instruction register and decoded fields
//   PC, PCPlus4          address of Instr and its successor
//   instr_valid          Instr is issued
//   misalign             sticky flag: a misaligned target was taken
//   instret              retired-instruction counter
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic            misalign,
    output logic [31:0]     instret
);

    fetch_state_e    state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     instret_q, instret_d;
    logic            misalign_q, misalign_d;
    logic            pc_load;
    logic [XLEN-1:0] pc_next;

    assign pc_next = PCSrc ? PCTarget : PCPlus4;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (PC)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            instr_q    <= NOP_INSTR;
            instret_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instret_d   = instret_q;
        misalign_d  = misalign_q;
        pc_load     = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    // The instruction retires even when its target is misaligned;
                    // only the PC update is suppressed and fetching stops.
                    instret_d = instret_q + 32'd1;
                    if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                        misalign_d = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        pc_load = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign imem_addr = PC;
    assign PCPlus4   = PC + XLEN'(4);
    assign Instr     = instr_q;
    assign op        = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7b5  = instr_q[30];
    assign misalign  = misalign_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus pushes the expected
// fetch address and issued-instruction record; a monitor pops and compares when
// imem_req or instr_valid rises. A second instance checks PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] instret;

    // Wrap-around instance with its own free-running memory.
    logic        reset2 = 1'b1;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] Instr2;
    logic [6:0]  op2;
    logic [2:0]  funct3_2;
    logic        funct7b5_2;
    logic [31:0] PC2;
    logic [31:0] PCPlus4_2;
    logic        instr_valid2;
    logic        misalign2;
    logic [31:0] instret2;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata), .Instr(Instr), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .PC(PC), .PCPlus4(PCPlus4), .instr_valid(instr_valid),
        .misalign(misalign), .instret(instret)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .PCSrc(1'b0), .PCTarget(32'h0), .stall(1'b0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_valid(1'b1),
        .imem_rdata(32'h0000_0013), .Instr(Instr2), .op(op2), .funct3(funct3_2),
        .funct7b5(funct7b5_2), .PC(PC2), .PCPlus4(PCPlus4_2),
        .instr_valid(instr_valid2), .misalign(misalign2), .instret(instret2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] instret;
    } exp_t;

    exp_t        exec_q[$];
    logic [31:0] addr_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit done2    = 1'b0;

    logic [31:0] model_pc      = 32'h0;
    logic [31:0] model_instret = 32'h0;
    logic [31:0] last_instr    = 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        logic prev_req = 1'b0;
        logic prev_valid = 1'b0;
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (imem_req && !prev_req) begin
                if (addr_q.size() == 0) flag_fail("unexpected_fetch");
                else begin
                    a = addr_q.pop_front();
                    chk("fetch_addr", imem_addr, a);
                end
            end
            if (instr_valid && !prev_valid) begin
                if (exec_q.size() == 0) flag_fail("unexpected_issue");
                else begin
                    e = exec_q.pop_front();
                    chk("issue_pc", PC, e.pc);
                    chk("issue_instr", Instr, e.instr);
                    chk("issue_op", {25'd0, op}, {25'd0, e.instr[6:0]});
                    chk("issue_funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
                    chk("issue_funct7b5", {31'd0, funct7b5}, {31'd0, e.instr[30]});
                    chk("issue_instret", instret, e.instret);
                    chk("issue_pcplus4", PCPlus4, e.pc + 32'd4);
                end
            end
            prev_req   = imem_req;
            prev_valid = instr_valid;
        end
    end

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        if (!imem_req) flag_fail("wait_req_timeout");
    endtask

    // One instruction: w memory wait cycles, s stalled EXEC cycles.
    task automatic fetch_one(input int w, input logic [31:0] instr, input logic pcsrc,
                             input logic [31:0] tgt, input int s);
        logic [31:0] cur_pc;
        logic [31:0] cur_ret;
        wait_req();
        for (int i = 0; i < w; i++) begin
            imem_valid = 1'b0;
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, model_pc);
            chk("wait_instr", Instr, last_instr);
            @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        PCSrc      = pcsrc;
        PCTarget   = tgt;
        stall      = (s > 0);
        cur_pc     = model_pc;
        cur_ret    = model_instret;
        exec_q.push_back('{pc: model_pc, instr: instr, instret: model_instret});
        last_instr = instr;
        model_instret++;
        if (!(pcsrc && tgt[1:0] != 2'b00)) begin
            model_pc = pcsrc ? tgt : model_pc + 32'd4;
            addr_q.push_back(model_pc);
        end
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (s > 0) begin
            for (int i = 0; i < s; i++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, instr_valid}, 32'd1);
                chk("stall_pc", PC, cur_pc);
                chk("stall_instret", instret, cur_ret);
            end
            stall = 1'b0;
            @(negedge clk);
            chk("post_stall_pc", PC, model_pc);
            chk("post_stall_instret", instret, model_instret);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, PC, 32'h0);
        chk({tag, "_instr"}, Instr, 32'h0000_0013);
        chk({tag, "_op"}, {25'd0, op}, 32'h13);
        chk({tag, "_funct3"}, {29'd0, funct3}, 32'd0);
        chk({tag, "_funct7b5"}, {31'd0, funct7b5}, 32'd0);
        chk({tag, "_pcplus4"}, PCPlus4, 32'h4);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation timeout");
    end

    // Wrap-around: RESET_PC = FFFF_FFFC, next PC is 0.
    initial begin : wrap_test
        @(negedge clk);
        @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4_2, 32'h0);
        @(negedge clk);
        chk("wrap_exec", {31'd0, instr_valid2}, 32'd1);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr2, 32'h0);
        chk("wrap_instret", instret2, 32'd1);
        done2 = 1'b1;
    end

    initial begin : stim
        int halt_req;
        @(negedge clk);
        check_reset_state("reset");
        addr_q.push_back(32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);

        fetch_one(0, 32'h0000_0013, 1'b0, 32'h0, 0);
        fetch_one(0, 32'h0000_0013, 1'b0, 32'h0, 0);
        fetch_one(3, 32'h0000_0013, 1'b0, 32'h0, 0);
        @(negedge clk);
        chk("instret_after_3", instret, 32'd3);

        // Taken branch (beq) to 0x40.
        fetch_one(0, 32'h0000_0463, 1'b1, 32'h0000_0040, 0);
        chk("branch_op", {25'd0, op}, 32'h63);
        // sub (funct7b5=1) stalled for 5 EXEC cycles.
        fetch_one(0, 32'h40B5_0533, 1'b0, 32'h0, 5);
        // xor, then taken to a misaligned target.
        fetch_one(0, 32'h0000_4033, 1'b1, 32'h0000_0042, 0);
        @(negedge clk);
        chk("misalign_flag", {31'd0, misalign}, 32'd1);
        chk("misalign_pc", PC, 32'h0000_0044);
        chk("misalign_instret", instret, model_instret);
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req || instr_valid) halt_req++;
        end
        chk("halt_quiet", halt_req, 0);

        // Reset out of HALT.
        reset = 1'b1;
        #1;
        check_reset_state("halt_reset");
        model_pc = 32'h0; model_instret = 32'h0; last_instr = 32'h0000_0013;
        addr_q.push_back(32'h0);
        @(negedge clk);
        reset = 1'b0;
        fetch_one(0, 32'h0000_0013, 1'b0, 32'h0, 0);

        // Reset during a FETCH wait at PC=4.
        wait_req();
        chk("midfetch_pc", PC, 32'h4);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midfetch_req_drop", {31'd0, imem_req}, 32'd0);
        chk("midfetch_pc_reset", PC, 32'h0);
        model_pc = 32'h0; model_instret = 32'h0; last_instr = 32'h0000_0013;
        addr_q.push_back(32'h0);
        @(negedge clk);
        reset = 1'b0;
        fetch_one(1, 32'h00A0_0093, 1'b0, 32'h0, 0);
        wait_req();
        chk("recover_instret", instret, 32'd1);
        chk("recover_pc", PC, 32'h4);

        for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
        if (!done2) flag_fail("wrap_test_timeout");
        chk("exec_q_drained", exec_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
